// File: rtl/idelay_cal_pkg.sv
// Shared types and defaults for the IDELAYE3 tap calibrator.
//   cal_state_t : calibration FSM states
//   tap_t       : tap value at the default tap width
//   CAL_PATTERN : default training word
package idelay_cal_pkg;

   localparam int unsigned CAL_TAP_W   = 9;
   localparam logic [7:0]  CAL_PATTERN = 8'hA5;

   typedef logic [CAL_TAP_W-1:0] tap_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_VTC_OFF,
      ST_LOAD,
      ST_SETTLE,
      ST_CHECK,
      ST_NEXT,
      ST_CENTER,
      ST_LOAD_FINAL,
      ST_VTC_ON
   } cal_state_t;

endpackage

// File: rtl/idelay_run_tracker.sv
// Longest contiguous passing-tap run bookkeeping.
//   clear        : drop open run and stored best
//   step/pass/tap: one scored tap per step pulse
//   fin_*_c      : best window as it would be if the open run were closed now
module idelay_run_tracker
   import idelay_cal_pkg::*;
#(
   parameter int unsigned TAP_W = CAL_TAP_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             step,
   input  logic             pass,
   input  logic [TAP_W-1:0] tap,
   output logic             fin_valid_c,
   output logic [TAP_W-1:0] fin_lo_c,
   output logic [TAP_W-1:0] fin_hi_c
);

   logic             run_open;
   logic             best_valid;
   logic [TAP_W-1:0] cur_lo;
   logic [TAP_W-1:0] cur_hi;
   logic [TAP_W-1:0] best_lo;
   logic [TAP_W-1:0] best_hi;
   logic             cur_wins_c;

   // Open run replaces best only when strictly longer, so ties keep the earlier run
   assign cur_wins_c  = run_open && (!best_valid || ((cur_hi - cur_lo) > (best_hi - best_lo)));
   assign fin_valid_c = best_valid | run_open;
   assign fin_lo_c    = cur_wins_c ? cur_lo : best_lo;
   assign fin_hi_c    = cur_wins_c ? cur_hi : best_hi;

   // Run open/close on each scored tap
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         run_open   <= 1'b0;
         best_valid <= 1'b0;
         cur_lo     <= '0;
         cur_hi     <= '0;
         best_lo    <= '0;
         best_hi    <= '0;
      end else if (step) begin
         if (pass) begin
            if (!run_open) begin
               cur_lo <= tap;
            end
            cur_hi   <= tap;
            run_open <= 1'b1;
         end else if (run_open) begin
            run_open <= 1'b0;
            if (cur_wins_c) begin
               best_valid <= 1'b1;
               best_lo    <= cur_lo;
               best_hi    <= cur_hi;
            end
         end
      end
   end

endmodule

// File: rtl/idelay_tap_calibrator.sv
// Sweeps an IDELAYE3 (VAR_LOAD, COUNT) tap, scores each tap against a training
// word, loads the centre of the longest passing window and re-enables VT comp.
//   clk, reset          : fabric clock, synchronous active-high reset
//   start               : 1-cycle calibration request (ignored while busy)
//   dly_rdy             : IDELAYCTRL RDY
//   rx_word, rx_valid   : deserialized lane data
//   cntvaluein,load     : IDELAYE3 tap value and load pulse
//   en_vtc              : IDELAYE3 EN_VTC
//   busy, done, fail    : status (done/fail sticky until next start)
//   eye_lo,eye_hi       : chosen window; tap_sel : tap finally loaded
module idelay_tap_calibrator
   import idelay_cal_pkg::*;
#(
   parameter int unsigned TAP_W       = CAL_TAP_W,
   parameter int unsigned TAP_MAX     = 511,
   parameter int unsigned TAP_STEP    = 8,
   parameter int unsigned VTC_WAIT    = 16,
   parameter int unsigned SETTLE      = 8,
   parameter int unsigned CHECK_WORDS = 64,
   parameter logic [7:0]  PATTERN     = CAL_PATTERN
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             dly_rdy,
   input  logic [7:0]       rx_word,
   input  logic             rx_valid,
   output logic [TAP_W-1:0] cntvaluein,
   output logic             load,
   output logic             en_vtc,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [TAP_W-1:0] eye_lo,
   output logic [TAP_W-1:0] eye_hi,
   output logic [TAP_W-1:0] tap_sel
);

   localparam int unsigned CNT_MAX =
      (VTC_WAIT > SETTLE) ? ((VTC_WAIT > CHECK_WORDS) ? VTC_WAIT : CHECK_WORDS)
                          : ((SETTLE > CHECK_WORDS) ? SETTLE : CHECK_WORDS);
   localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
   localparam int unsigned SUM_W = TAP_W + 1;

   cal_state_t       state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [TAP_W-1:0] tap, tap_d;
   logic             tap_ok, tap_ok_d;
   logic [TAP_W-1:0] cntvaluein_d, eye_lo_d, eye_hi_d, tap_sel_d;
   logic             load_d, en_vtc_d, busy_d, done_d, fail_d;

   logic             trk_clr_c, trk_step_c;
   logic             fin_valid_c;
   logic [TAP_W-1:0] fin_lo_c, fin_hi_c;
   logic [SUM_W-1:0] tap_sum_c, sel_sum_c;

   idelay_run_tracker #(.TAP_W(TAP_W)) u_run_tracker (
      .clk         (clk),
      .reset       (reset),
      .clear       (trk_clr_c),
      .step        (trk_step_c),
      .pass        (tap_ok),
      .tap         (tap),
      .fin_valid_c (fin_valid_c),
      .fin_lo_c    (fin_lo_c),
      .fin_hi_c    (fin_hi_c)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         tap        <= '0;
         tap_ok     <= 1'b0;
         cntvaluein <= '0;
         load       <= 1'b0;
         en_vtc     <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         eye_lo     <= '0;
         eye_hi     <= '0;
         tap_sel    <= '0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         tap        <= tap_d;
         tap_ok     <= tap_ok_d;
         cntvaluein <= cntvaluein_d;
         load       <= load_d;
         en_vtc     <= en_vtc_d;
         busy       <= busy_d;
         done       <= done_d;
         fail       <= fail_d;
         eye_lo     <= eye_lo_d;
         eye_hi     <= eye_hi_d;
         tap_sel    <= tap_sel_d;
      end
   end

   // Next state and next output values
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      tap_d        = tap;
      tap_ok_d     = tap_ok;
      cntvaluein_d = cntvaluein;
      load_d       = 1'b0;
      en_vtc_d     = en_vtc;
      busy_d       = busy;
      done_d       = done;
      fail_d       = fail;
      eye_lo_d     = eye_lo;
      eye_hi_d     = eye_hi;
      tap_sel_d    = tap_sel;
      trk_clr_c    = 1'b0;
      trk_step_c   = 1'b0;
      // Sums carry one extra bit so the end-of-sweep test and centre never wrap
      tap_sum_c    = SUM_W'(tap) + SUM_W'(TAP_STEP);
      sel_sum_c    = SUM_W'(fin_lo_c) + SUM_W'(fin_hi_c);

      case (state)
         ST_IDLE: begin
            if (start) begin
               done_d    = 1'b0;
               fail_d    = 1'b0;
               busy_d    = 1'b1;
               tap_d     = '0;
               trk_clr_c = 1'b1;
               state_d   = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (dly_rdy) begin
               en_vtc_d = 1'b0;
               cnt_d    = '0;
               state_d  = ST_VTC_OFF;
            end
         end
         ST_VTC_OFF: begin
            en_vtc_d = 1'b0;
            if (cnt == CNT_W'(VTC_WAIT - 1)) begin
               cnt_d   = '0;
               state_d = ST_LOAD;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_LOAD: begin
            cntvaluein_d = tap;
            load_d       = 1'b1;
            cnt_d        = '0;
            state_d      = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt == CNT_W'(SETTLE - 1)) begin
               cnt_d    = '0;
               tap_ok_d = 1'b1;
               state_d  = ST_CHECK;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_CHECK: begin
            if (rx_valid) begin
               if (rx_word != PATTERN) begin
                  tap_ok_d = 1'b0;
                  state_d  = ST_NEXT;
               end else if (cnt == CNT_W'(CHECK_WORDS - 1)) begin
                  state_d = ST_NEXT;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
         end
         ST_NEXT: begin
            trk_step_c = 1'b1;
            if (tap_sum_c <= SUM_W'(TAP_MAX)) begin
               tap_d   = TAP_W'(tap_sum_c);
               state_d = ST_LOAD;
            end else begin
               state_d = ST_CENTER;
            end
         end
         ST_CENTER: begin
            if (fin_valid_c) begin
               eye_lo_d  = fin_lo_c;
               eye_hi_d  = fin_hi_c;
               tap_sel_d = TAP_W'(sel_sum_c >> 1);
               fail_d    = 1'b0;
            end else begin
               eye_lo_d  = '0;
               eye_hi_d  = '0;
               tap_sel_d = '0;
               fail_d    = 1'b1;
            end
            cnt_d   = '0;
            state_d = ST_LOAD_FINAL;
         end
         ST_LOAD_FINAL: begin
            // First cycle issues the load, then SETTLE cycles elapse
            if (cnt == '0) begin
               cntvaluein_d = tap_sel;
               load_d       = 1'b1;
            end
            if (cnt == CNT_W'(SETTLE)) begin
               state_d = ST_VTC_ON;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_VTC_ON: begin
            en_vtc_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = !fail;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Losing RDY mid-sweep restarts from tap 0 once RDY returns; VT comp stays off
      if (!dly_rdy && ((state == ST_VTC_OFF) || (state == ST_LOAD) ||
                       (state == ST_SETTLE)  || (state == ST_CHECK))) begin
         state_d      = ST_WAIT_RDY;
         tap_d        = '0;
         cnt_d        = '0;
         trk_clr_c    = 1'b1;
         load_d       = 1'b0;
         cntvaluein_d = cntvaluein;
         en_vtc_d     = 1'b0;
      end
   end

endmodule

// File: tb/tb_idelay_tap_calibrator.sv
// Directed bench for idelay_tap_calibrator with a lane model and result scoreboard.
module tb_idelay_tap_calibrator;
   import idelay_cal_pkg::*;

   localparam int unsigned VTC_WAIT = 16;
   localparam logic [7:0]  PAT      = 8'hA5;

   typedef struct {
      int lo;
      int hi;
      int sel;
      int dn;
      int fl;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic       dly_rdy;
   logic [7:0] rx_word;
   logic       rx_valid;
   tap_t       cntvaluein;
   logic       load;
   logic       en_vtc;
   logic       busy;
   logic       done;
   logic       fail;
   tap_t       eye_lo;
   tap_t       eye_hi;
   tap_t       tap_sel;

   int   ncmp = 0;
   int   nerr = 0;
   exp_t sbq[$];

   // lane model state
   int   w_lo0 = 1, w_hi0 = 0, w_lo1 = 1, w_hi1 = 0;
   int   lane_tap = 0;
   int   loads = 0;
   int   last_load = -1;
   logic load_prev = 1'b0;
   int   vtc_low_cnt = 0;
   bit   first_pending = 1'b0;

   idelay_tap_calibrator dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dly_rdy    (dly_rdy),
      .rx_word    (rx_word),
      .rx_valid   (rx_valid),
      .cntvaluein (cntvaluein),
      .load       (load),
      .en_vtc     (en_vtc),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .eye_lo     (eye_lo),
      .eye_hi     (eye_hi),
      .tap_sel    (tap_sel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit in_win(input int t);
      return ((t >= w_lo0) && (t <= w_hi0)) || ((t >= w_lo1) && (t <= w_hi1));
   endfunction

   // Lane model plus load/en_vtc protocol monitors, all on the falling edge
   initial begin
      rx_valid = 1'b0;
      rx_word  = 8'h00;
      forever begin
         @(negedge clk);
         if (load === 1'b1) begin
            chk("load_single_cycle", int'(load_prev), 0);
            if (first_pending) begin
               chk("vtc_wait_before_load", int'(vtc_low_cnt >= int'(VTC_WAIT)), 1);
               first_pending = 1'b0;
            end
            lane_tap  = int'(cntvaluein);
            last_load = int'(cntvaluein);
            loads++;
         end
         load_prev = load;
         if (en_vtc === 1'b0) begin
            if (vtc_low_cnt == 0) first_pending = 1'b1;
            vtc_low_cnt++;
         end else begin
            vtc_low_cnt   = 0;
            first_pending = 1'b0;
         end
         rx_valid = ~rx_valid;
         rx_word  = in_win(lane_tap) ? PAT : ~PAT;
      end
   end

   task automatic set_win(input int lo0, input int hi0, input int lo1, input int hi1);
      w_lo0 = lo0; w_hi0 = hi0; w_lo1 = lo1; w_hi1 = hi1;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 30000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_finished"}, int'(busy), 0);
   endtask

   task automatic sb_check(input string tag);
      exp_t e;
      chk({tag, "_sb_pending"}, sbq.size(), 1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, "_done"}, int'(done), e.dn);
         chk({tag, "_fail"}, int'(fail), e.fl);
         chk({tag, "_tap_sel"}, int'(tap_sel), e.sel);
         chk({tag, "_en_vtc"}, int'(en_vtc), 1);
         if (e.dn == 1) begin
            chk({tag, "_eye_lo"}, int'(eye_lo), e.lo);
            chk({tag, "_eye_hi"}, int'(eye_hi), e.hi);
            chk({tag, "_last_load"}, last_load, e.sel);
         end
      end
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      start   = 1'b0;
      dly_rdy = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_cntvaluein", int'(cntvaluein), 0);
      chk("rst_load", int'(load), 0);
      chk("rst_en_vtc", int'(en_vtc), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_eye_lo", int'(eye_lo), 0);
      chk("rst_eye_hi", int'(eye_hi), 0);
      chk("rst_tap_sel", int'(tap_sel), 0);
      reset = 1'b0;

      // single window, with a stray start while busy
      set_win(120, 260, 1, 0);
      sbq.push_back('{lo: 120, hi: 256, sel: 188, dn: 1, fl: 0});
      loads = 0;
      pulse_start();
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t1_busy_after_stray_start", int'(busy), 1);
      wait_idle("t1");
      sb_check("t1");
      chk("t1_load_count", loads, 65);

      // two equal windows: earlier one kept
      set_win(16, 64, 200, 248);
      sbq.push_back('{lo: 16, hi: 64, sel: 40, dn: 1, fl: 0});
      pulse_start();
      wait_idle("t2");
      sb_check("t2");

      // no passing tap
      set_win(1, 0, 1, 0);
      sbq.push_back('{lo: 0, hi: 0, sel: 0, dn: 0, fl: 1});
      pulse_start();
      wait_idle("t3");
      sb_check("t3");

      // window running into the last swept tap
      set_win(480, 511, 1, 0);
      sbq.push_back('{lo: 480, hi: 504, sel: 492, dn: 1, fl: 0});
      pulse_start();
      wait_idle("t4");
      sb_check("t4");

      // RDY late: nothing happens until it rises
      set_win(300, 340, 1, 0);
      sbq.push_back('{lo: 304, hi: 336, sel: 320, dn: 1, fl: 0});
      dly_rdy = 1'b0;
      loads   = 0;
      pulse_start();
      repeat (100) @(negedge clk);
      chk("t5_no_load_before_rdy", loads, 0);
      chk("t5_en_vtc_before_rdy", int'(en_vtc), 1);
      chk("t5_busy_before_rdy", int'(busy), 1);
      dly_rdy = 1'b1;
      wait_idle("t5");
      sb_check("t5");

      // reset in the middle of scoring tap 0
      set_win(0, 511, 1, 0);
      loads = 0;
      pulse_start();
      n = 0;
      while (loads == 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("t6_first_load_seen", int'(loads > 0), 1);
      repeat (20) @(negedge clk);
      chk("t6_busy_in_check", int'(busy), 1);
      chk("t6_en_vtc_in_check", int'(en_vtc), 0);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_en_vtc", int'(en_vtc), 1);
      chk("t6_rst_load", int'(load), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_cntvaluein", int'(cntvaluein), 0);
      reset = 1'b0;

      // recovery after reset
      set_win(40, 48, 1, 0);
      sbq.push_back('{lo: 40, hi: 48, sel: 44, dn: 1, fl: 0});
      pulse_start();
      wait_idle("t7");
      sb_check("t7");

      chk("sb_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
